// File: rtl/trig_rec_pkg.sv
// Record layout shared by the trigger event recorder, its FIFO wrapper and readout code.
// Strobe fields occupy the low 11 bits; the timestamp sits directly above them.
package trig_rec_pkg;
    localparam int DEF_TS_W = 32;
    localparam int STROBE_W = 11;
    localparam int REC_W    = DEF_TS_W + STROBE_W;

    localparam int LCT_LSB  = 0;
    localparam int TMB_BIT  = 8;
    localparam int ALCT_BIT = 9;
    localparam int L1A_BIT  = 10;
    localparam int TS_LSB   = 11;

    typedef struct packed {
        logic       l1a;
        logic       alct_dav;
        logic       tmb_dav;
        logic [7:0] lct;
    } trig_strobe_t;

    typedef struct packed {
        logic [DEF_TS_W-1:0] ts;
        trig_strobe_t        strobe;
    } trig_rec_t;

    function automatic logic strobe_active(input trig_strobe_t s);
        return s.l1a | s.alct_dav | s.tmb_dav | (s.lct != 8'h00);
    endfunction
endpackage

// File: rtl/trig_event_recorder_if.sv
// Control, strobe and readout signals of the trigger event recorder.
// The recorder uses the slave view; a host or bench drives it through master.
interface trig_event_recorder_if #(
    parameter int TS_W       = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int DROP_W     = 16
);
    logic                                   en;
    logic                                   clear;
    logic                                   l1a;
    logic                                   alct_dav;
    logic                                   tmb_dav;
    logic [7:0]                             lct;
    logic                                   rd_en;
    logic [TS_W+trig_rec_pkg::STROBE_W-1:0] dout;
    logic                                   dout_valid;
    logic [DEPTH_LOG2:0]                    count;
    logic                                   overflow;
    logic [DROP_W-1:0]                      drop_cnt;
    logic [TS_W-1:0]                        ts_now;

    modport master (
        output en, clear, l1a, alct_dav, tmb_dav, lct, rd_en,
        input  dout, dout_valid, count, overflow, drop_cnt, ts_now
    );

    modport slave (
        input  en, clear, l1a, alct_dav, tmb_dav, lct, rd_en,
        output dout, dout_valid, count, overflow, drop_cnt, ts_now
    );
endinterface

// File: rtl/trig_rec_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head output.
// Pointers carry a wrap bit so full and empty are distinguishable without a counter.
module trig_rec_fifo #(
    parameter int WIDTH = 43,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && !flush && (!full || do_pop);
    assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // The head register follows the slot rd_next points at; when that slot is the one
    // being written this edge, the incoming word is forwarded, and when empty it holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            rd_ptr <= rd_next;
            if (rd_next != wr_ptr) begin
                dout <= mem[rd_next[AW-1:0]];
            end else if (do_push) begin
                dout <= din;
            end
        end
    end
endmodule

// File: rtl/trig_event_recorder.sv
// Timestamps every active trigger-strobe cycle and queues the record for readout.
// One input register stage aligns strobes with the pre-increment counter value.
module trig_event_recorder
    import trig_rec_pkg::*;
#(
    parameter int TS_W       = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int DROP_W     = 16
) (
    input logic                    clk,
    input logic                    rst,
    trig_event_recorder_if.slave   bus
);
    localparam int RW = TS_W + STROBE_W;

    logic [TS_W-1:0]   ts_q;
    trig_strobe_t      pins;
    trig_strobe_t      stage_strobe;
    logic              stage_valid;
    logic [TS_W-1:0]   stage_ts;
    logic [RW-1:0]     wr_rec;
    logic              push;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_q;

    assign pins.l1a      = bus.l1a;
    assign pins.alct_dav = bus.alct_dav;
    assign pins.tmb_dav  = bus.tmb_dav;
    assign pins.lct      = bus.lct;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else if (bus.clear) begin
            ts_q <= '0;
        end else if (bus.en) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // A strobe seen during clear belongs to the fresh epoch, so it is stamped zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid  <= 1'b0;
            stage_strobe <= '0;
            stage_ts     <= '0;
        end else begin
            stage_valid  <= bus.en && strobe_active(pins);
            stage_strobe <= pins;
            stage_ts     <= bus.clear ? '0 : ts_q;
        end
    end

    always_comb begin
        wr_rec                     = '0;
        wr_rec[TS_LSB +: TS_W]     = stage_ts;
        wr_rec[L1A_BIT]            = stage_strobe.l1a;
        wr_rec[ALCT_BIT]           = stage_strobe.alct_dav;
        wr_rec[TMB_BIT]            = stage_strobe.tmb_dav;
        wr_rec[LCT_LSB +: 8]       = stage_strobe.lct;
    end

    // The staged record from before a clear is discarded along with the FIFO contents.
    assign push = stage_valid && !bus.clear;
    assign drop = push && fifo_full && !bus.rd_en;

    trig_rec_fifo #(
        .WIDTH (RW),
        .AW    (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.clear),
        .push  (push),
        .din   (wr_rec),
        .pop   (bus.rd_en),
        .dout  (bus.dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (bus.count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (bus.clear) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != '1) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    assign bus.dout_valid = !fifo_empty;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.ts_now     = ts_q;
endmodule

// File: tb/tb_trig_event_recorder.sv
// Bench for trig_event_recorder: a full-size instance and a small one (8-bit ts, depth 4,
// 2-bit drop count) share every stimulus and are both compared against a queue model.
module tb_trig_event_recorder;
    typedef struct {
        logic       en;
        logic       clear;
        logic       l1a;
        logic       alct;
        logic       tmb;
        logic [7:0] lct;
        logic       rd;
    } stim_t;

    typedef struct {
        stim_t           s;
        logic            exp_valid;
        int              exp_count;
        longint unsigned exp_ts_now;
        logic [63:0]     exp_dout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clear, l1a, alct_dav, tmb_dav, rd_en;
    logic [7:0] lct;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned     depth_m  [2] = '{64, 4};
    longint unsigned ts_mask  [2] = '{64'hFFFF_FFFF, 64'hFF};
    longint unsigned drop_max [2] = '{65535, 3};
    longint unsigned m_ts     [2];
    longint unsigned m_drop   [2];
    logic            m_ovf    [2];
    logic            pend_v   [2];
    logic [63:0]     pend_rec [2];
    logic [63:0]     shown    [2];
    logic [63:0]     mq       [2][$];

    trig_event_recorder_if #(.TS_W(32), .DEPTH_LOG2(6), .DROP_W(16)) bus_a ();
    trig_event_recorder_if #(.TS_W(8),  .DEPTH_LOG2(2), .DROP_W(2))  bus_b ();

    assign bus_a.en = en;          assign bus_b.en = en;
    assign bus_a.clear = clear;    assign bus_b.clear = clear;
    assign bus_a.l1a = l1a;        assign bus_b.l1a = l1a;
    assign bus_a.alct_dav = alct_dav; assign bus_b.alct_dav = alct_dav;
    assign bus_a.tmb_dav = tmb_dav;   assign bus_b.tmb_dav = tmb_dav;
    assign bus_a.lct = lct;        assign bus_b.lct = lct;
    assign bus_a.rd_en = rd_en;    assign bus_b.rd_en = rd_en;

    trig_event_recorder #(.TS_W(32), .DEPTH_LOG2(6), .DROP_W(16)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    trig_event_recorder #(.TS_W(8), .DEPTH_LOG2(2), .DROP_W(2)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic e, input logic c, input logic a, input logic al,
                                 input logic t, input logic [7:0] l, input logic r);
        stim_t s;
        s.en = e; s.clear = c; s.l1a = a; s.alct = al; s.tmb = t; s.lct = l; s.rd = r;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic v, input int c,
                                 input longint unsigned t, input logic [63:0] d);
        vec_t x;
        x.s = s; x.exp_valid = v; x.exp_count = c; x.exp_ts_now = t; x.exp_dout = d;
        return x;
    endfunction

    function automatic logic [63:0] make_rec(input longint unsigned ts, input logic a,
                                             input logic al, input logic t, input logic [7:0] l);
        return (64'(ts) << 11) | (64'(a) << 10) | (64'(al) << 9) | (64'(t) << 8) | 64'(l);
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ts[k] = 0; m_drop[k] = 0; m_ovf[k] = 1'b0;
            pend_v[k] = 1'b0; pend_rec[k] = '0; shown[k] = '0;
            mq[k].delete();
        end
    endtask

    // Reads are applied before the staged write, so a pop always makes room for it.
    task automatic model_step(input stim_t s);
        for (int k = 0; k < 2; k++) begin
            if (s.clear) begin
                mq[k].delete(); m_ovf[k] = 1'b0; m_drop[k] = 0;
            end else begin
                if (s.rd && mq[k].size() > 0) void'(mq[k].pop_front());
                if (pend_v[k]) begin
                    if (mq[k].size() < int'(depth_m[k])) mq[k].push_back(pend_rec[k]);
                    else begin
                        m_ovf[k] = 1'b1;
                        if (m_drop[k] < drop_max[k]) m_drop[k]++;
                    end
                end
            end
            pend_v[k]   = s.en && (s.l1a || s.alct || s.tmb || (s.lct != 8'h00));
            pend_rec[k] = make_rec(s.clear ? 0 : m_ts[k], s.l1a, s.alct, s.tmb, s.lct);
            if (s.clear) m_ts[k] = 0;
            else if (s.en) m_ts[k] = (m_ts[k] + 1) & ts_mask[k];
            if (mq[k].size() > 0) shown[k] = mq[k][0];
        end
    endtask

    task automatic checkOutput();
        check_val("a.dout_valid", 64'(bus_a.dout_valid), 64'(mq[0].size() > 0));
        check_val("a.count",      64'(bus_a.count),      64'(mq[0].size()));
        check_val("a.dout",       64'(bus_a.dout),       shown[0]);
        check_val("a.ts_now",     64'(bus_a.ts_now),     m_ts[0]);
        check_val("a.overflow",   64'(bus_a.overflow),   64'(m_ovf[0]));
        check_val("a.drop_cnt",   64'(bus_a.drop_cnt),   m_drop[0]);
        check_val("b.dout_valid", 64'(bus_b.dout_valid), 64'(mq[1].size() > 0));
        check_val("b.count",      64'(bus_b.count),      64'(mq[1].size()));
        check_val("b.dout",       64'(bus_b.dout),       shown[1]);
        check_val("b.ts_now",     64'(bus_b.ts_now),     m_ts[1]);
        check_val("b.overflow",   64'(bus_b.overflow),   64'(m_ovf[1]));
        check_val("b.drop_cnt",   64'(bus_b.drop_cnt),   m_drop[1]);
    endtask

    task automatic applyStimulus(input stim_t s);
        en = s.en; clear = s.clear; l1a = s.l1a; alct_dav = s.alct;
        tmb_dav = s.tmb; lct = s.lct; rd_en = s.rd;
        @(posedge clk);
        model_step(s);
        #1;
        checkOutput();
    endtask

    initial begin
        vec_t  vecs [13];
        stim_t s;
        logic  act;

        en = 0; clear = 0; l1a = 0; alct_dav = 0; tmb_dav = 0; lct = '0; rd_en = 0;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checkOutput();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 0));

        vecs[0]  = mkv(mk(1,0,1,0,0,8'h05,0), 0, 0, 64'h11, 64'h0);
        vecs[1]  = mkv(mk(1,0,0,0,0,8'h00,0), 1, 1, 64'h12, make_rec(64'h10,1,0,0,8'h05));
        vecs[2]  = mkv(mk(0,0,0,0,0,8'h80,0), 1, 1, 64'h12, make_rec(64'h10,1,0,0,8'h05));
        vecs[3]  = mkv(mk(0,0,0,0,0,8'h00,0), 1, 1, 64'h12, make_rec(64'h10,1,0,0,8'h05));
        vecs[4]  = mkv(mk(1,0,0,1,1,8'h00,1), 0, 0, 64'h13, make_rec(64'h10,1,0,0,8'h05));
        vecs[5]  = mkv(mk(1,0,0,0,0,8'h00,0), 1, 1, 64'h14, make_rec(64'h12,0,1,1,8'h00));
        vecs[6]  = mkv(mk(1,0,0,0,0,8'h01,1), 0, 0, 64'h15, make_rec(64'h12,0,1,1,8'h00));
        vecs[7]  = mkv(mk(1,0,1,0,0,8'h00,1), 1, 1, 64'h16, make_rec(64'h14,0,0,0,8'h01));
        vecs[8]  = mkv(mk(1,0,0,0,0,8'h00,1), 1, 1, 64'h17, make_rec(64'h15,1,0,0,8'h00));
        vecs[9]  = mkv(mk(1,1,1,0,0,8'h22,0), 0, 0, 64'h00, make_rec(64'h15,1,0,0,8'h00));
        vecs[10] = mkv(mk(1,0,0,0,1,8'h00,0), 1, 1, 64'h01, make_rec(64'h00,1,0,0,8'h22));
        vecs[11] = mkv(mk(1,1,0,0,0,8'h00,0), 0, 0, 64'h00, make_rec(64'h00,1,0,0,8'h22));
        vecs[12] = mkv(mk(1,0,0,0,0,8'h00,0), 0, 0, 64'h01, make_rec(64'h00,1,0,0,8'h22));

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].s);
            check_val($sformatf("vec%0d.valid", i),  64'(bus_a.dout_valid), 64'(vecs[i].exp_valid));
            check_val($sformatf("vec%0d.count", i),  64'(bus_a.count),      64'(vecs[i].exp_count));
            check_val($sformatf("vec%0d.ts_now", i), 64'(bus_a.ts_now),     vecs[i].exp_ts_now);
            check_val($sformatf("vec%0d.dout", i),   64'(bus_a.dout),       vecs[i].exp_dout);
        end

        // Overflow on the depth-4 instance, then a write that coincides with a read while full.
        applyStimulus(mk(1, 1, 0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 6; i++) applyStimulus(mk(1, 0, 1, 0, 0, 8'(i + 1), 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 0));
        check_val("ovf.b_count", 64'(bus_b.count), 64'd4);
        check_val("ovf.b_flag",  64'(bus_b.overflow), 64'd1);
        check_val("ovf.b_drops", 64'(bus_b.drop_cnt), 64'd2);
        check_val("ovf.b_head",  64'(bus_b.dout[7:0]), 64'd1);
        check_val("ovf.a_count", 64'(bus_a.count), 64'd6);
        applyStimulus(mk(1, 0, 0, 0, 1, 8'h07, 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 1));
        check_val("fullrw.b_drops", 64'(bus_b.drop_cnt), 64'd2);
        check_val("fullrw.b_count", 64'(bus_b.count), 64'd4);
        check_val("fullrw.b_head",  64'(bus_b.dout[7:0]), 64'd2);
        for (int i = 0; i < 3; i++) applyStimulus(mk(1, 0, 0, 1, 0, 8'h00, 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 0));
        check_val("sat.b_drops", 64'(bus_b.drop_cnt), 64'd3);

        // Burst of eight back-to-back records, read out in order.
        applyStimulus(mk(1, 1, 0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 8; i++) applyStimulus(mk(1, 0, 1, 0, 0, 8'(8'h40 + i), 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 0));
        check_val("burst.a_count", 64'(bus_a.count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("burst.ts%0d", i), 64'(bus_a.dout[42:11]), 64'(i));
            applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 1));
        end
        check_val("burst.a_empty", 64'(bus_a.dout_valid), 64'd0);

        // Counter wrap on the 8-bit instance.
        applyStimulus(mk(1, 1, 0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 254; i++) applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 3; i++) applyStimulus(mk(1, 0, 1, 0, 0, 8'h00, 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 0));
        check_val("wrap.ts0", 64'(bus_b.dout[18:11]), 64'hFE);
        applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 1));
        check_val("wrap.ts1", 64'(bus_b.dout[18:11]), 64'hFF);
        applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 1));
        check_val("wrap.ts2", 64'(bus_b.dout[18:11]), 64'h00);
        check_val("wrap.a_ts", 64'(bus_a.dout[42:11]), 64'd256);

        // Asynchronous reset between edges in the middle of a burst.
        for (int i = 0; i < 5; i++) applyStimulus(mk(1, 0, 0, 0, 1, 8'h11, 0));
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(mk(1, 0, 1, 0, 0, 8'h00, 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 8'h00, 0));
        check_val("postrst.a_ts",    64'(bus_a.dout[42:11]), 64'd0);
        check_val("postrst.a_count", 64'(bus_a.count), 64'd1);

        // Random traffic: a write-heavy phase that fills the FIFOs, then a read-heavy phase.
        for (int i = 0; i < 1600; i++) begin
            act     = 1'($urandom_range(1));
            s.en    = ($urandom_range(7) != 0);
            s.clear = ($urandom_range(199) == 0);
            s.l1a   = act && 1'($urandom_range(1));
            s.alct  = act && 1'($urandom_range(1));
            s.tmb   = act && 1'($urandom_range(1));
            s.lct   = (act && $urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
            s.rd    = (i < 700) ? ($urandom_range(4) == 0) : ($urandom_range(9) < 6);
            applyStimulus(s);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
